// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*WIDTH-bit unsigned dividend / WIDTH-bit unsigned divisor.
// One quotient bit is produced per clock behind a start/busy/done handshake. Results are
// registered and held until the next accepted start.
//
// Optional feature macro: SEQ_DIVIDER_DZ_FLAG_EN
//   defined   -> adds div_by_zero_o; a zero divisor skips the iterative phase and finishes
//                in the cycle after the accept edge.
//   undefined -> no div_by_zero_o; a zero divisor runs the full 2*WIDTH steps.
// Either way a zero divisor yields quotient = all ones, remainder = dividend[WIDTH-1:0].
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [2*WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]     divisor_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   quotient_o,
  output logic [WIDTH-1:0]     remainder_o
`ifdef SEQ_DIVIDER_DZ_FLAG_EN
  ,
  output logic                 div_by_zero_o
`endif
);

  localparam int unsigned DvdW = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(DvdW);
  localparam logic [CntW-1:0] LastCnt = CntW'(DvdW - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [DvdW-1:0]   quotient_q;
  logic [WIDTH-1:0]  remainder_q;
  logic [CntW-1:0]   cnt_q;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom,
  // so after 2*WIDTH steps this register holds the quotient.
  logic [DvdW-1:0]   dvd_q;
  logic [DvdW-1:0]   dvd_d;
  logic [WIDTH-1:0]  dvs_q;
  // Stored partial remainder is WIDTH bits: after each restoring step it is below the
  // divisor, and with a zero divisor the shifted-out MSB is discarded anyway.
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_d;
  logic [WIDTH:0]    r_shift;
  logic              q_bit;
`ifdef SEQ_DIVIDER_DZ_FLAG_EN
  logic              dz_q;
`endif

  // One restoring step: shift in the next dividend bit, compare at WIDTH+1 bits, subtract.
  always_comb begin
    r_shift = {r_q, dvd_q[DvdW-1]};
    q_bit   = (r_shift >= {1'b0, dvs_q});
    r_d     = q_bit ? WIDTH'(r_shift - {1'b0, dvs_q}) : r_shift[WIDTH-1:0];
    dvd_d   = {dvd_q[DvdW-2:0], q_bit};
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      r_q         <= '0;
`ifdef SEQ_DIVIDER_DZ_FLAG_EN
      dz_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
`ifdef SEQ_DIVIDER_DZ_FLAG_EN
            if (divisor_i == '0) begin
              // Zero divisor short-circuits straight to a done pulse.
              state_q     <= StDone;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend_i[WIDTH-1:0];
              dz_q        <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              dvd_q   <= dividend_i;
              dvs_q   <= divisor_i;
              r_q     <= '0;
              cnt_q   <= '0;
              dz_q    <= 1'b0;
            end
`else
            state_q <= StRun;
            busy_q  <= 1'b1;
            dvd_q   <= dividend_i;
            dvs_q   <= divisor_i;
            r_q     <= '0;
            cnt_q   <= '0;
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          r_q   <= r_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            // A zero divisor naturally yields all-ones quotient and dividend low bits here.
            state_q     <= StDone;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= dvd_d;
            remainder_q <= r_d;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
`ifdef SEQ_DIVIDER_DZ_FLAG_EN
  assign div_by_zero_o = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands checked against
// a plain-arithmetic reference model. Latency is counted in clock edges after the accept edge.
module tb_seq_divider;

  localparam int unsigned W = 8;
`ifdef SEQ_DIVIDER_DZ_FLAG_EN
  localparam int DzLat = 0;
`else
  localparam int DzLat = 16;
`endif
  localparam int RunLat = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2*W-1:0]   dividend;
  logic [W-1:0]     divisor;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   quotient;
  logic [W-1:0]     remainder;
`ifdef SEQ_DIVIDER_DZ_FLAG_EN
  logic             dz;
`endif

  int n_checks = 0;
  int n_errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .busy_o       (busy),
    .done_o       (done),
    .quotient_o   (quotient),
    .remainder_o  (remainder)
`ifdef SEQ_DIVIDER_DZ_FLAG_EN
    ,
    .div_by_zero_o(dz)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer division, with the defined divide-by-zero result.
  task automatic model(input logic [2*W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] q, output logic [W-1:0] r);
    if (b == 0) begin
      q = '1;
      r = a[W-1:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Caller is at a negedge; returns at the first negedge where done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one start at the next negedge, then wait for done.
  task automatic run_div(input logic [2*W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
  endtask

  initial begin
    int lat;
    logic [2*W-1:0] eq;
    logic [W-1:0] er;
    logic [2*W-1:0] a;
    logic [W-1:0] b;
    bit seen_done;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quot", quotient, 0);
    check("reset_rem", remainder, 0);
`ifdef SEQ_DIVIDER_DZ_FLAG_EN
    check("reset_dz", dz, 0);
`endif
    rst = 1'b0;

    // 1000 / 7
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", busy, 1);
    wait_done(lat);
    check("1000_7_lat", lat, RunLat);
    check("1000_7_q", quotient, 16'd142);
    check("1000_7_r", remainder, 8'd6);
    check("1000_7_busy_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("hold_q", quotient, 16'd142);

    // Boundary operands
    run_div(16'hFFFF, 8'hFF, lat);
    check("ffff_ff_q", quotient, 16'h0101);
    check("ffff_ff_r", remainder, 0);
    run_div(16'hFFFF, 8'h01, lat);
    check("ffff_01_q", quotient, 16'hFFFF);
    check("ffff_01_r", remainder, 0);

    // 5/10 then back-to-back 100/3 started in the done cycle
    run_div(16'd5, 8'd10, lat);
    check("5_10_q", quotient, 0);
    check("5_10_r", remainder, 5);
    start = 1'b1; dividend = 16'd100; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_drop", done, 0);
    check("b2b_busy", busy, 1);
    check("b2b_hold_q", quotient, 0);
    check("b2b_hold_r", remainder, 5);
    wait_done(lat);
    check("b2b_lat", lat, RunLat);
    check("100_3_q", quotient, 16'd33);
    check("100_3_r", remainder, 1);

    // Starts and operand changes during a run are ignored
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(negedge clk);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      start    = (lat == 3 || lat == 9);
      dividend = 16'($urandom);
      divisor  = 8'd5;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("ignore_lat", lat, RunLat);
    check("ignore_q", quotient, 16'd142);
    check("ignore_r", remainder, 8'd6);
    @(negedge clk);
    check("ignore_no_restart", busy, 0);

    // Reset mid-run discards the division
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("midrun_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    seen_done = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("rst_no_done", seen_done, 0);

    // Divide by zero
    run_div(16'h1234, 8'h00, lat);
    check("dz_lat", lat, DzLat);
    check("dz_q", quotient, 16'hFFFF);
    check("dz_r", remainder, 8'h34);
`ifdef SEQ_DIVIDER_DZ_FLAG_EN
    check("dz_flag", dz, 1);
    repeat (3) @(negedge clk);
    check("dz_flag_hold", dz, 1);
    check("dz_done_low", done, 0);
    @(negedge clk);
    start = 1'b1; dividend = 16'd50; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    check("dz_flag_clear", dz, 0);
    wait_done(lat);
    check("after_dz_q", quotient, 16'd7);
`endif

    // Random operands against the reference model
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      model(a, b, eq, er);
      run_div(a, b, lat);
      check("rnd_lat", lat, RunLat);
      check("rnd_q", quotient, eq);
      check("rnd_r", remainder, er);
      check("rnd_invariant", (32'(quotient) * 32'(b) + 32'(remainder) == 32'(a))
                             && (remainder < b), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
